data_sram_responder: RTL
========================

Name: data_sram_responder

Overview:
Slave end of the core's data-side SRAM port. Serves the core's request-in-EX, data-in-MEM1 timing with exactly one cycle of read latency. Backs the port with a local word RAM plus a small MMIO block: a free-running timer with a compare interrupt, and a console byte FIFO drained by a valid/ready handshake. Instantiated beside the pipeline top in the SoC wrapper; its port names mirror the core's data_sram_* outputs.

Parameters:
RAM_AW, 12, log2 of RAM depth in 64-bit words (default 32 KiB).
RAM_BASE, 64'h0000_0000_8000_0000, byte base of RAM; must be aligned to 2^(RAM_AW+3).
MMIO_BASE, 64'h0000_0000_1000_0000, byte base of a 32-byte MMIO window.
CON_DEPTH, 4, console FIFO entries; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
data_sram_en  in  1  request valid this cycle
data_sram_we  in  8  byte write enables; all zero means read
data_sram_addr  in  64  byte address; bits [2:0] ignored (doubleword access)
data_sram_wdata  in  64  write data, byte lane i = bits [8i+7:8i]
data_sram_rdata  out  64  read data, valid the cycle after the read request
timer_irq  out  1  registered level: mtime >= mtimecmp (unsigned)
con_valid  out  1  console FIFO non-empty
con_data  out  8  head byte of the console FIFO
con_ready  in  1  consumer accepts the head byte when con_valid && con_ready
decode_err  out  1  one-cycle pulse, the cycle after any access that hits no region

Behaviour:
- Reset (async, rst_n=0): rdata=0, mtime=0, mtimecmp=all-ones, timer_irq=0, FIFO empty (con_valid=0, con_data=0), overflow=0, decode_err=0. RAM contents are not reset. Reset asserted mid-operation discards any in-flight read and all FIFO contents.
- Decode, on data_sram_addr[63:3]:
  - RAM when addr[63:RAM_AW+3] == RAM_BASE[63:RAM_AW+3]; index = addr[RAM_AW+2:3].
  - MMIO when addr[63:5] == MMIO_BASE[63:5]; the register is selected by offset addr[4:3].
    - 0: MTIME, read/write.
    - 1: MTIMECMP, read/write.
    - 2: CONSOLE, write-only; reads return 0.
    - 3: STATUS, read {61'b0, overflow, irq, full}; writing 1 to bit 2 clears overflow.
  - Any other address: reads return 0, writes are ignored, decode_err pulses.
- Read (en=1, we=0): data_sram_rdata is updated at the next edge and holds until the next read. Writes and idle cycles leave rdata unchanged.
- Write (en=1, we!=0): only the enabled byte lanes of the target are updated. No rdata update. One request per cycle. A read in cycle N+1 of an address written in cycle N returns the new data.
- mtime: increments by 1 every cycle and wraps at 2^64. A write to MTIME in the same cycle takes priority: enabled lanes take wdata, disabled lanes take the pre-increment value, and no increment occurs that cycle. A read returns the register value before that cycle's update.
- timer_irq: registered from the current mtime and mtimecmp each cycle, so it lags by 1 cycle. Writing MTIMECMP above mtime deasserts it on the cycle after the write takes effect.
- Console FIFO:
  - Push: a CONSOLE write with we[0]=1 pushes wdata[7:0]. A write with we[0]=0 does nothing.
  - Pop: happens when con_valid && con_ready.
  - Full with no pop that cycle: the push is dropped and overflow is set (sticky).
  - Full with a pop that cycle: the push is accepted.
  - Empty: con_valid=0 and con_data holds its last value. A push into an empty FIFO makes con_valid=1 on the next cycle.
  - If a STATUS write clears overflow in the same cycle a drop sets it, the set wins.
- Pointers wrap modulo CON_DEPTH. Occupancy uses a count of log2(CON_DEPTH)+1 bits.

Decomposition:
- Shared package nova_mmio_pkg holds:
  - MMIO offset constants (MTIME_OFF, MTIMECMP_OFF, CON_OFF, STATUS_OFF).
  - STATUS bit indices.
  - The default RAM_BASE and MMIO_BASE values.
- One sub-module, con_fifo: parameterised depth and width; push/pop/full/empty/count; single clock; async active-low reset.
- Timer and decode stay inline.

Test Plan:
- Write 64'h1122_3344_5566_7788 with we=8'hFF to RAM_BASE+8. Next cycle, write we=8'h01 with wdata=0xAA. Next cycle, read. -> One cycle later rdata=64'h1122_3344_5566_77AA.
- Reset release, then read MTIME at cycle 10 -> rdata=10. Write MTIMECMP=20 -> timer_irq rises 1 cycle after mtime reaches 20. Write MTIMECMP=all-ones -> timer_irq falls.
- Hold con_ready=0 and push bytes 0x41..0x45 (5 pushes, CON_DEPTH=4). -> STATUS read = 3'b101; con_data=0x41. Raise con_ready -> bytes drain as 0x41, 0x42, 0x43, 0x44, then con_valid=0.
- FIFO full, push 0x50 and pop in the same cycle -> no overflow; drain order ends with 0x50.
- Read address 64'h2000_0000 -> rdata=0 and decode_err pulses exactly one cycle. A write to the same address leaves all state unchanged.
- Assert rst_n=0 asynchronously mid-drain, between clock edges -> con_valid, rdata and timer_irq drop immediately. RAM data is retained.

Source files
------------

// File: rtl/nova_mmio_pkg.sv
// ----------------------------------------------------------------------------
// nova_mmio_pkg
// Shared constants for the data-side SRAM responder: MMIO register offsets
// (address bits [4:3] inside the 32-byte window), STATUS bit positions,
// default region bases, the decode region type and a byte-lane merge helper.
// ----------------------------------------------------------------------------
package nova_mmio_pkg;

    // Register select, taken from addr[4:3] inside the MMIO window.
    localparam logic [1:0] MTIME_OFF    = 2'd0;
    localparam logic [1:0] MTIMECMP_OFF = 2'd1;
    localparam logic [1:0] CON_OFF      = 2'd2;
    localparam logic [1:0] STATUS_OFF   = 2'd3;

    // STATUS register layout.
    localparam int unsigned STATUS_FULL_BIT = 0;
    localparam int unsigned STATUS_IRQ_BIT  = 1;
    localparam int unsigned STATUS_OVF_BIT  = 2;

    localparam logic [63:0] DEF_RAM_BASE  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DEF_MMIO_BASE = 64'h0000_0000_1000_0000;

    typedef enum logic [1:0] {
        RegNone,
        RegRam,
        RegMmio
    } region_e;

    // Replace the byte lanes of old_val selected by be with those of new_val.
    function automatic logic [63:0] merge_lanes(input logic [63:0] old_val,
                                                input logic [63:0] new_val,
                                                input logic [7:0]  be);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// ----------------------------------------------------------------------------
// data_sram_responder_if
// Data-side SRAM port between the core (master) and the responder (slave).
//   data_sram_en     request valid this cycle
//   data_sram_we     byte write enables, zero means read
//   data_sram_addr   byte address, doubleword granular
//   data_sram_wdata  write data
//   data_sram_rdata  read data, one cycle after the read request
// ----------------------------------------------------------------------------
interface data_sram_responder_if;

    logic        data_sram_en;
    logic [7:0]  data_sram_we;
    logic [63:0] data_sram_addr;
    logic [63:0] data_sram_wdata;
    logic [63:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );

endinterface

// File: rtl/con_fifo.sv
// ----------------------------------------------------------------------------
// con_fifo
// Single-clock FIFO for the console byte stream.
//   clk, rst_n  clock and asynchronous active-low reset
//   i_push      push request; accepted when not full, or full with a pop
//   i_wdata     data to push
//   i_pop       pop request; ignored when empty
//   o_rdata     head entry; holds the last popped value while empty
//   o_full      DEPTH entries held
//   o_empty     no entries held
//   o_count     occupancy, log2(DEPTH)+1 bits
// ----------------------------------------------------------------------------
module con_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic [WIDTH-1:0] r_last;

    logic             w_pop;
    logic             w_push_acc;
    logic [CntW-1:0]  w_count_nxt;

    assign o_full  = (r_count == CntW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    assign w_pop      = i_pop && !o_empty;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
    assign w_push_acc = i_push && (!o_full || w_pop);

    // Show the last consumed byte while empty so the head output never glitches.
    assign o_rdata = o_empty ? r_last : r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push_acc, w_pop})
            2'b10:   w_count_nxt = r_count + CntW'(1);
            2'b01:   w_count_nxt = r_count - CntW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_last   <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// ----------------------------------------------------------------------------
// data_sram_responder
// Slave end of the core's data-side SRAM port with one cycle of read latency.
// Backs the port with a local doubleword RAM and a 32-byte MMIO window
// holding a free-running timer with compare interrupt and a console FIFO.
//   clk, rst_n   clock and asynchronous active-low reset
//   data_sram    request/response bus (slave modport)
//   timer_irq    registered mtime >= mtimecmp
//   con_valid    console FIFO non-empty
//   con_data     console head byte
//   con_ready    consumer takes the head byte when con_valid && con_ready
//   decode_err   one-cycle pulse after an access that hits no region
// ----------------------------------------------------------------------------
module data_sram_responder
    import nova_mmio_pkg::*;
#(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [63:0] RAM_BASE  = DEF_RAM_BASE,
    parameter logic [63:0] MMIO_BASE = DEF_MMIO_BASE,
    parameter int unsigned CON_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_sram_responder_if.slave  data_sram,
    output logic                  timer_irq,
    output logic                  con_valid,
    output logic [7:0]            con_data,
    input  logic                  con_ready,
    output logic                  decode_err
);

    localparam int unsigned RamDepth = 1 << RAM_AW;
    localparam int unsigned CntW     = $clog2(CON_DEPTH) + 1;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic [63:0]       w_addr;
    logic [7:0]        w_we;
    logic [63:0]       w_wdata;
    logic              w_rd;
    logic              w_wr;
    region_e           w_region;
    logic [1:0]        w_off;
    logic [RAM_AW-1:0] w_idx;

    assign w_addr  = data_sram.data_sram_addr;
    assign w_we    = data_sram.data_sram_we;
    assign w_wdata = data_sram.data_sram_wdata;
    assign w_rd    = data_sram.data_sram_en && (w_we == 8'h00);
    assign w_wr    = data_sram.data_sram_en && (w_we != 8'h00);
    assign w_off   = w_addr[4:3];
    assign w_idx   = w_addr[RAM_AW+2:3];

    always_comb begin
        w_region = RegNone;
        if (w_addr[63:RAM_AW+3] == RAM_BASE[63:RAM_AW+3]) begin
            w_region = RegRam;
        end else if (w_addr[63:5] == MMIO_BASE[63:5]) begin
            w_region = RegMmio;
        end
    end

    logic w_mmio_wr;
    logic w_mtime_wr;
    logic w_mtimecmp_wr;
    logic w_con_push;
    logic w_ovf_clr;

    assign w_mmio_wr     = w_wr && (w_region == RegMmio);
    assign w_mtime_wr    = w_mmio_wr && (w_off == MTIME_OFF);
    assign w_mtimecmp_wr = w_mmio_wr && (w_off == MTIMECMP_OFF);
    assign w_con_push    = w_mmio_wr && (w_off == CON_OFF) && w_we[0];
    assign w_ovf_clr     = w_mmio_wr && (w_off == STATUS_OFF) && w_we[0]
                           && w_wdata[STATUS_OVF_BIT];

    // ------------------------------------------------------------------------
    // RAM (contents survive reset)
    // ------------------------------------------------------------------------
    logic [63:0] r_ram [RamDepth];

    always_ff @(posedge clk) begin
        if (w_wr && (w_region == RegRam)) begin
            r_ram[w_idx] <= merge_lanes(r_ram[w_idx], w_wdata, w_we);
        end
    end

    // ------------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------------
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_irq;
    logic [63:0] w_mtime_nxt;
    logic [63:0] w_mtimecmp_nxt;

    // A software write replaces the increment for that cycle.
    assign w_mtime_nxt    = w_mtime_wr ? merge_lanes(r_mtime, w_wdata, w_we)
                                       : r_mtime + 64'd1;
    assign w_mtimecmp_nxt = w_mtimecmp_wr ? merge_lanes(r_mtimecmp, w_wdata, w_we)
                                          : r_mtimecmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= '1;
            r_irq      <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_nxt;
            r_mtimecmp <= w_mtimecmp_nxt;
            r_irq      <= (r_mtime >= r_mtimecmp);
        end
    end

    assign timer_irq = r_irq;

    // ------------------------------------------------------------------------
    // Console FIFO and overflow flag
    // ------------------------------------------------------------------------
    logic            w_con_full;
    logic            w_con_empty;
    logic [CntW-1:0] w_con_count;
    logic            w_con_pop;
    logic            w_con_drop;
    logic            r_ovf;

    assign con_valid  = !w_con_empty;
    assign w_con_pop  = con_valid && con_ready;
    assign w_con_drop = w_con_push && w_con_full && !w_con_pop;

    con_fifo #(
        .DEPTH (CON_DEPTH),
        .WIDTH (8)
    ) u_con_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_con_push),
        .i_wdata (w_wdata[7:0]),
        .i_pop   (w_con_pop),
        .o_rdata (con_data),
        .o_full  (w_con_full),
        .o_empty (w_con_empty),
        .o_count (w_con_count)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_con_drop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Read path and decode error
    // ------------------------------------------------------------------------
    logic [63:0] w_status;
    logic [63:0] w_rd_val;
    logic [63:0] r_rdata;
    logic        r_dec_err;

    always_comb begin
        w_status                  = '0;
        w_status[STATUS_FULL_BIT] = w_con_full;
        w_status[STATUS_IRQ_BIT]  = r_irq;
        w_status[STATUS_OVF_BIT]  = r_ovf;
    end

    // Timer reads return the value before this cycle's update.
    always_comb begin
        w_rd_val = '0;
        if (w_region == RegRam) begin
            w_rd_val = r_ram[w_idx];
        end else if (w_region == RegMmio) begin
            case (w_off)
                MTIME_OFF:    w_rd_val = r_mtime;
                MTIMECMP_OFF: w_rd_val = r_mtimecmp;
                CON_OFF:      w_rd_val = '0;
                STATUS_OFF:   w_rd_val = w_status;
                default:      w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata   <= '0;
            r_dec_err <= 1'b0;
        end else begin
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
            r_dec_err <= data_sram.data_sram_en && (w_region == RegNone);
        end
    end

    assign data_sram.data_sram_rdata = r_rdata;
    assign decode_err                = r_dec_err;

    // Doubleword offset bits and FIFO occupancy are intentionally not consumed.
    logic w_unused;
    assign w_unused = ^{w_addr[2:0], w_con_count};

endmodule
